// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the unified memory port arbiter.
//   - arb_state_t : access sequencer states (IDLE, ISSUE, WAIT, DONE)
//   - M_CPU/M_EXT : master identifiers stored with a latched command
//   - LAT_W       : width of the read-latency down-counter (MEM_LAT <= 15)
//   - STARVE_W    : width of the starvation counter (MAX_WAIT <= 255)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_EXT = 1'b1;

  localparam int LAT_W    = 4;
  localparam int STARVE_W = 8;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt
//   Saturating starvation counter for the low-priority master.
//   Counts every cycle the master is pending but not granted, saturates at
//   MAX_WAIT, and clears on a grant or when the request goes away.
//   Ports:
//     clk     in  clock
//     rst     in  synchronous reset, active-high
//     pend    in  low-priority master is requesting
//     gnt     in  low-priority master is granted this cycle
//     starved out registered flag: counter currently equals MAX_WAIT
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pend,
  input  logic gnt,
  output logic starved
);

  localparam logic [STARVE_W-1:0] MAX_W = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] cnt_r;
  logic [STARVE_W-1:0] cnt_s;
  logic                starved_r;

  // Next count: clear on grant or idle request, otherwise saturating increment
  always_comb begin
    cnt_s = cnt_r;
    if (!pend || gnt) begin
      cnt_s = {STARVE_W{1'b0}};
    end else if (cnt_r == MAX_W) begin
      cnt_s = cnt_r;
    end else begin
      cnt_s = cnt_r + {{(STARVE_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register; the flag is computed from the next count so that it
  // always equals (cnt_r == MAX_W) while still coming straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {STARVE_W{1'b0}};
      starved_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      starved_r <= (cnt_s == MAX_W);
    end
  end

  assign starved = starved_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port instruction/data memory between the CPU (m0) and a
//   loader/debug port (m1). m0 has fixed priority; m1 wins once it has been
//   denied MAX_WAIT consecutive cycles. Each access is sequenced
//   IDLE -> ISSUE -> [WAIT] -> DONE and completes with a one-cycle ack.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     m0_req/we/addr/wdata           CPU command, held stable until m0_ack
//     m0_ack, m0_rdata               completion pulse and read data (0 on writes)
//     m1_req/we/addr/wdata           loader command, held stable until m1_ack
//     m1_ack, m1_rdata               completion pulse and read data (0 on writes)
//     mem_en, mem_we                 one-cycle access strobe and write enable
//     mem_addr, mem_wdata            registered command of the granted master
//     mem_rdata                      memory data, valid MEM_LAT cycles after mem_en
//     busy                           high whenever the sequencer is not IDLE
//   Optional feature macro MEM_ARB_STATS_EN adds gnt_cnt0/gnt_cnt1, 32-bit
//   wrapping counts of ISSUE cycles per master.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]   gnt_cnt0,
  output logic [31:0]   gnt_cnt1
`endif
);

  // WAIT is entered holding MEM_LAT-1 and captures data when it reaches 0
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  arb_state_t       state_r, state_s;
  logic [LAT_W-1:0] lat_cnt_r, lat_cnt_s;
  logic             id_r, id_s;
  logic             we_r, we_s;
  logic [AW-1:0]    addr_r, addr_s;
  logic [DW-1:0]    wdata_r, wdata_s;
  logic             mem_en_r, mem_en_s;
  logic             mem_we_r, mem_we_s;
  logic             m0_ack_r, m0_ack_s;
  logic             m1_ack_r, m1_ack_s;
  logic [DW-1:0]    m0_rdata_r, m0_rdata_s;
  logic [DW-1:0]    m1_rdata_r, m1_rdata_s;
  logic             busy_r, busy_s;

  logic             starved_s;
  logic             any_req_s;
  logic             win_m1_s;
  logic             gnt_m1_s;
  logic             done_s;
  logic [DW-1:0]    done_data_s;

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .pend    (m1_req),
    .gnt     (gnt_m1_s),
    .starved (starved_s)
  );

  assign any_req_s = m0_req | m1_req;
  // m1 must be requesting to win: a starved flag can still be set in the
  // cycle m1 withdraws its request
  assign win_m1_s  = m1_req & (starved_s | ~m0_req);

  // Sequencer next-state, command latch and completion decode
  always_comb begin
    state_s     = state_r;
    lat_cnt_s   = lat_cnt_r;
    id_s        = id_r;
    we_s        = we_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    gnt_m1_s    = 1'b0;
    done_s      = 1'b0;
    done_data_s = {DW{1'b0}};
    m0_ack_s    = 1'b0;
    m1_ack_s    = 1'b0;
    m0_rdata_s  = {DW{1'b0}};
    m1_rdata_s  = {DW{1'b0}};

    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s  = ISSUE;
          mem_en_s = 1'b1;
          gnt_m1_s = win_m1_s;
          if (win_m1_s) begin
            id_s    = M_EXT;
            we_s    = m1_we;
            addr_s  = m1_addr;
            wdata_s = m1_wdata;
          end else begin
            id_s    = M_CPU;
            we_s    = m0_we;
            addr_s  = m0_addr;
            wdata_s = m0_wdata;
          end
          mem_we_s = we_s;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          state_s     = DONE;
          done_s      = 1'b1;
          done_data_s = {DW{1'b0}};
        end else begin
          state_s   = WAIT;
          lat_cnt_s = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_cnt_r == {LAT_W{1'b0}}) begin
          state_s     = DONE;
          done_s      = 1'b1;
          done_data_s = mem_rdata;
        end else begin
          lat_cnt_s = lat_cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Ack and data are registered on the edge entering DONE, so they are
    // visible for exactly the DONE cycle
    if (done_s) begin
      if (id_r == M_EXT) begin
        m1_ack_s   = 1'b1;
        m1_rdata_s = done_data_s;
      end else begin
        m0_ack_s   = 1'b1;
        m0_rdata_s = done_data_s;
      end
    end else begin
      m0_ack_s = 1'b0;
      m1_ack_s = 1'b0;
    end

    busy_s = (state_s != IDLE);
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      lat_cnt_r  <= {LAT_W{1'b0}};
      id_r       <= M_CPU;
      we_r       <= 1'b0;
      addr_r     <= {AW{1'b0}};
      wdata_r    <= {DW{1'b0}};
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      m0_ack_r   <= 1'b0;
      m1_ack_r   <= 1'b0;
      m0_rdata_r <= {DW{1'b0}};
      m1_rdata_r <= {DW{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      lat_cnt_r  <= lat_cnt_s;
      id_r       <= id_s;
      we_r       <= we_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      mem_en_r   <= mem_en_s;
      mem_we_r   <= mem_we_s;
      m0_ack_r   <= m0_ack_s;
      m1_ack_r   <= m1_ack_s;
      m0_rdata_r <= m0_rdata_s;
      m1_rdata_r <= m1_rdata_s;
      busy_r     <= busy_s;
    end
  end

  assign m0_ack    = m0_ack_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_ack    = m1_ack_r;
  assign m1_rdata  = m1_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] gnt_cnt0_r;
  logic [31:0] gnt_cnt1_r;

  // Per-master grant statistics, counted once per ISSUE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0_r <= 32'd0;
      gnt_cnt1_r <= 32'd0;
    end else if (state_r == ISSUE) begin
      if (id_r == M_EXT) begin
        gnt_cnt1_r <= gnt_cnt1_r + 32'd1;
      end else begin
        gnt_cnt0_r <= gnt_cnt0_r + 32'd1;
      end
    end
  end

  assign gnt_cnt0 = gnt_cnt0_r;
  assign gnt_cnt1 = gnt_cnt1_r;
`endif

endmodule
